// File: rtl/bus_arbiter_msi_if.sv
// Shared snooping-bus signal bundle between the arbiter and the requesters/memory.
// master is the arbiter's view; slave is the requester/memory side.
interface bus_arbiter_msi_if #(
    parameter int BUS_W = 9
);
    logic [2:0]       req;
    logic [BUS_W-1:0] msg0;
    logic [BUS_W-1:0] msg1;
    logic [BUS_W-1:0] msg2;
    logic [2:0]       snoop_flush;
    logic [BUS_W-1:0] flush_data;
    logic             mem_ack;
    logic [2:0]       grant;
    logic [BUS_W-1:0] bus_msg;
    logic             bus_valid;
    logic             bus_wb;
    logic             mem_req;
    logic [2:0]       done;
    logic             err;

    modport master (
        input  req, msg0, msg1, msg2, snoop_flush, flush_data, mem_ack,
        output grant, bus_msg, bus_valid, bus_wb, mem_req, done, err
    );

    modport slave (
        output req, msg0, msg1, msg2, snoop_flush, flush_data, mem_ack,
        input  grant, bus_msg, bus_valid, bus_wb, mem_req, done, err
    );
endinterface

// File: rtl/bus_arbiter_msi.sv
// Round-robin arbiter and transaction sequencer for the 3-requester MSI snooping bus.
// One transaction at a time: ADDR broadcast, SNOOP, then FLUSH or MEM, then DONE.
module bus_arbiter_msi #(
    parameter int BUS_W       = 9,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    bus_arbiter_msi_if.master   bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, SNOOP, FLUSH, MEM, DONE} state_t;

    state_t           state;
    logic [1:0]       ptr, win, sel, c0, c1, c2;
    logic             any, multi;
    logic [CW-1:0]    cnt;
    logic [2:0]       grant, done, flush_m;
    logic [BUS_W-1:0] bus_msg, sel_msg;
    logic             bus_valid, bus_wb, mem_req, err;
    logic [1:0]       op;

    // Scan order ptr, ptr+1, ptr+2 (mod 3); ptr is always kept in 0..2.
    always_comb begin
        c0  = ptr;
        c1  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        c2  = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        any = |bus.req;
        if (bus.req[c0])      sel = c0;
        else if (bus.req[c1]) sel = c1;
        else                  sel = c2;
        case (sel)
            2'd0:    sel_msg = bus.msg0;
            2'd1:    sel_msg = bus.msg1;
            default: sel_msg = bus.msg2;
        endcase
    end

    // The owner never snoops its own line.
    assign flush_m = bus.snoop_flush & ~grant;
    assign multi   = |(flush_m & (flush_m - 3'd1));
    assign op      = bus_msg[BUS_W-1 -: 2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            grant     <= '0;
            bus_msg   <= '0;
            bus_valid <= 1'b0;
            bus_wb    <= 1'b0;
            mem_req   <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
        end else begin
            bus_valid <= 1'b0;
            bus_wb    <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    win       <= sel;
                    grant     <= 3'b001 << sel;
                    bus_msg   <= sel_msg;
                    bus_valid <= 1'b1;
                    state     <= ADDR;
                end
                ADDR: state <= SNOOP;
                SNOOP: begin
                    if (op == 2'b00 || op == 2'b11) begin
                        done  <= 3'b001 << win;
                        state <= DONE;
                    end else if (|flush_m) begin
                        // Flush data is the same wire for any flusher, so the
                        // lowest-index choice only matters for the err report.
                        bus_msg   <= bus.flush_data;
                        bus_valid <= 1'b1;
                        bus_wb    <= 1'b1;
                        err       <= multi;
                        state     <= FLUSH;
                    end else begin
                        mem_req <= 1'b1;
                        state   <= MEM;
                    end
                end
                FLUSH: begin
                    done  <= 3'b001 << win;
                    state <= DONE;
                end
                MEM: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_ack) begin
                        mem_req <= 1'b0;
                        done    <= 3'b001 << win;
                        state   <= DONE;
                    end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        done    <= 3'b001 << win;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    grant <= '0;
                    ptr   <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant;
    assign bus.bus_msg   = bus_msg;
    assign bus.bus_valid = bus_valid;
    assign bus.bus_wb    = bus_wb;
    assign bus.mem_req   = mem_req;
    assign bus.done      = done;
    assign bus.err       = err;
endmodule
